// File: rtl/mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mux2_arbiter
// Burst-locked round-robin arbiter driving the select of a shared 2:1 lane.
// Optional grant/stall statistics when MUX2_ARB_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in0_valid,
    output logic             io_in0_ready,
    input  logic [WIDTH-1:0] io_in0_bits,
    input  logic             io_in0_last,
    input  logic             io_in1_valid,
    output logic             io_in1_ready,
    input  logic [WIDTH-1:0] io_in1_bits,
    input  logic             io_in1_last,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    output logic             io_out_last,
    output logic             io_sel,
`ifdef MUX2_ARB_STATS_EN
    output logic [15:0]      io_grant_cnt0,
    output logic [15:0]      io_grant_cnt1,
    output logic [15:0]      io_stall_cnt,
`endif
    output logic             io_busy
);

    localparam int              CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             xfer;
    logic             release_now;

    // Datapath follows the registered select, so it never glitches mid-grant.
    always_comb begin
        io_out_bits  = sel_q ? io_in1_bits : io_in0_bits;
        io_out_last  = sel_q ? io_in1_last : io_in0_last;
        io_out_valid = ((state_q == GRANT0) && io_in0_valid) ||
                       ((state_q == GRANT1) && io_in1_valid);
        io_in0_ready = (state_q == GRANT0) && io_out_ready;
        io_in1_ready = (state_q == GRANT1) && io_out_ready;
        io_sel       = sel_q;
        io_busy      = (state_q != IDLE);
    end

    assign xfer        = io_out_valid && io_out_ready;
    assign release_now = io_out_last || (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (io_in0_valid && (!io_in1_valid || !rr_ptr_q)) begin
                    state_d = GRANT0;
                    sel_d   = 1'b0;
                end else if (io_in1_valid) begin
                    state_d = GRANT1;
                    sel_d   = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (xfer) begin
                    if (release_now) begin
                        // Hand priority to the other side; a forced release
                        // therefore lets a waiting peer in before the remainder.
                        state_d    = IDLE;
                        rr_ptr_d   = ~sel_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            sel_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt1_q, stall_cnt_q;
    logic        enter0, enter1, stall;

    assign enter0 = (state_q == IDLE) && (state_d == GRANT0);
    assign enter1 = (state_q == IDLE) && (state_d == GRANT1);
    assign stall  = io_out_valid && !io_out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            if (enter0 && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_q <= grant_cnt0_q + 16'd1;
            if (enter1 && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_q <= grant_cnt1_q + 16'd1;
            if (stall && (stall_cnt_q != 16'hFFFF))   stall_cnt_q  <= stall_cnt_q + 16'd1;
        end
    end

    assign io_grant_cnt0 = grant_cnt0_q;
    assign io_grant_cnt1 = grant_cnt1_q;
    assign io_stall_cnt  = stall_cnt_q;
`endif

endmodule
`default_nettype wire
